// File: rtl/ram_arbiter.sv
// ram_arbiter
// Shares the single SDRAM port of sdram_block between NCH masters. Every
// upstream channel and the downstream port use the same busy / rd_ready /
// rd_ack handshake. Arbitration is round-robin (PRIO=0) or fixed priority
// with channel 0 highest (PRIO=1). At most one read is outstanding, and the
// read data is routed back to the channel that issued the read.
//
// Ports
//   clk, rst          : clock, asynchronous active-low reset
//   m_addr/m_wr_data  : per-channel address / write data, channel i at [i*W +: W]
//   m_wr_en/m_rd_en   : per-channel write / read request (write wins if both set)
//   m_busy            : request on channel i is not accepted this cycle
//   m_rd_data/ready   : read data and its valid flag, routed to the owner only
//   m_rd_ack          : owner consumes its read data
//   ram_*             : downstream port towards sdram_block
//   grant             : current or last owning channel (debug)
module ram_arbiter #(
  parameter int NCH  = 2,
  parameter int AW   = 24,
  parameter int DW   = 16,
  parameter int PRIO = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NCH*AW-1:0]        m_addr,
  input  logic [NCH*DW-1:0]        m_wr_data,
  input  logic [NCH-1:0]           m_wr_en,
  input  logic [NCH-1:0]           m_rd_en,
  output logic [NCH-1:0]           m_busy,
  output logic [NCH*DW-1:0]        m_rd_data,
  output logic [NCH-1:0]           m_rd_ready,
  input  logic [NCH-1:0]           m_rd_ack,
  output logic [AW-1:0]            ram_addr,
  output logic [DW-1:0]            ram_wr_data,
  output logic                     ram_wr_en,
  output logic                     ram_rd_en,
  input  logic                     ram_busy,
  input  logic [DW-1:0]            ram_rd_data,
  input  logic                     ram_rd_ready,
  output logic                     ram_rd_ack,
  output logic [$clog2(NCH)-1:0]   grant
);

  localparam int GW = $clog2(NCH);

  typedef enum logic [1:0] {IDLE, GRANT, WAIT_RD} state_t;

  state_t          state_q, state_d;
  logic [GW-1:0]   grant_q, grant_d;
  logic [GW-1:0]   rr_q, rr_d;

  logic [NCH-1:0]  req;
  logic [GW-1:0]   winner;
  logic            found;
  logic [GW:0]     cand;

  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_wr_data;
  logic            sel_wr;
  logic            sel_rd;
  logic            sel_ack;
  logic            rd_ack;
  logic [GW-1:0]   rr_next;

  assign req   = m_wr_en | m_rd_en;
  assign grant = grant_q;

  // Winner selection. Round-robin scans upward from rr with a manual wrap so
  // the index stays GW bits wide; fixed priority scans downward so the
  // lowest requesting index is the last one written.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    cand   = '0;
    if (PRIO != 0) begin
      for (int i = NCH - 1; i >= 0; i--) begin
        if (req[i]) winner = GW'(i);
      end
    end else begin
      for (int k = 0; k < NCH; k++) begin
        cand = {1'b0, rr_q} + (GW + 1)'(k);
        if (cand >= (GW + 1)'(NCH)) cand = cand - (GW + 1)'(NCH);
        if (!found && req[cand[GW-1:0]]) begin
          winner = cand[GW-1:0];
          found  = 1'b1;
        end
      end
    end
  end

  // Multiplexer picking the granted channel's request fields.
  always_comb begin
    sel_addr    = '0;
    sel_wr_data = '0;
    sel_wr      = 1'b0;
    sel_rd      = 1'b0;
    sel_ack     = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (grant_q == GW'(i)) begin
        sel_addr    = m_addr[i*AW +: AW];
        sel_wr_data = m_wr_data[i*DW +: DW];
        sel_wr      = m_wr_en[i];
        sel_rd      = m_rd_en[i];
        sel_ack     = m_rd_ack[i];
      end
    end
  end

  assign rr_next = (grant_q == GW'(NCH - 1)) ? '0 : grant_q + GW'(1);

  // Next state and outputs. All outputs derive from the registered state so
  // an asynchronous reset drives them to their idle values immediately.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_d        = rr_q;
    m_busy      = '1;
    m_rd_data   = '0;
    m_rd_ready  = '0;
    ram_addr    = '0;
    ram_wr_data = '0;
    ram_wr_en   = 1'b0;
    ram_rd_en   = 1'b0;
    rd_ack      = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req) begin
          grant_d = winner;
          state_d = GRANT;
        end
      end
      GRANT: begin
        ram_addr    = sel_addr;
        ram_wr_data = sel_wr_data;
        ram_wr_en   = sel_wr;
        ram_rd_en   = sel_rd & ~sel_wr;
        for (int i = 0; i < NCH; i++) begin
          if (grant_q == GW'(i)) m_busy[i] = ram_busy;
        end
        if (sel_wr || sel_rd) begin
          if (!ram_busy) begin
            rr_d    = rr_next;
            state_d = sel_wr ? IDLE : WAIT_RD;
          end
        end else begin
          // Withdrawal: nothing was issued and rr keeps its value.
          state_d = IDLE;
        end
      end
      WAIT_RD: begin
        for (int i = 0; i < NCH; i++) begin
          if (grant_q == GW'(i)) begin
            m_rd_data[i*DW +: DW] = ram_rd_data;
            m_rd_ready[i]         = ram_rd_ready;
          end
        end
        rd_ack = sel_ack & ram_rd_ready;
        if (rd_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign ram_rd_ack = rd_ack;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter
// Directed bench for ram_arbiter with three channels. A round-robin instance
// and a fixed-priority instance share the same stimulus; the fixed-priority
// instance is only checked during the fairness sequence.
module tb_ram_arbiter;

  localparam int NCH = 3;
  localparam int AW  = 24;
  localparam int DW  = 16;

  logic              clk;
  logic              rst;
  logic [NCH*AW-1:0] m_addr;
  logic [NCH*DW-1:0] m_wr_data;
  logic [NCH-1:0]    m_wr_en;
  logic [NCH-1:0]    m_rd_en;
  logic [NCH-1:0]    m_rd_ack;
  logic              ram_busy;
  logic [DW-1:0]     ram_rd_data;
  logic              ram_rd_ready;

  logic [NCH-1:0]    m_busy,      fp_m_busy;
  logic [NCH*DW-1:0] m_rd_data,   fp_m_rd_data;
  logic [NCH-1:0]    m_rd_ready,  fp_m_rd_ready;
  logic [AW-1:0]     ram_addr,    fp_ram_addr;
  logic [DW-1:0]     ram_wr_data, fp_ram_wr_data;
  logic              ram_wr_en,   fp_ram_wr_en;
  logic              ram_rd_en,   fp_ram_rd_en;
  logic              ram_rd_ack,  fp_ram_rd_ack;
  logic [1:0]        grant,       fp_grant;

  int errors = 0;
  int checks = 0;
  logic [1:0] exp_order [6] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};

  ram_arbiter #(.NCH(NCH), .AW(AW), .DW(DW), .PRIO(0)) u_rr (
    .clk(clk), .rst(rst), .m_addr(m_addr), .m_wr_data(m_wr_data),
    .m_wr_en(m_wr_en), .m_rd_en(m_rd_en), .m_busy(m_busy),
    .m_rd_data(m_rd_data), .m_rd_ready(m_rd_ready), .m_rd_ack(m_rd_ack),
    .ram_addr(ram_addr), .ram_wr_data(ram_wr_data), .ram_wr_en(ram_wr_en),
    .ram_rd_en(ram_rd_en), .ram_busy(ram_busy), .ram_rd_data(ram_rd_data),
    .ram_rd_ready(ram_rd_ready), .ram_rd_ack(ram_rd_ack), .grant(grant)
  );

  ram_arbiter #(.NCH(NCH), .AW(AW), .DW(DW), .PRIO(1)) u_fp (
    .clk(clk), .rst(rst), .m_addr(m_addr), .m_wr_data(m_wr_data),
    .m_wr_en(m_wr_en), .m_rd_en(m_rd_en), .m_busy(fp_m_busy),
    .m_rd_data(fp_m_rd_data), .m_rd_ready(fp_m_rd_ready), .m_rd_ack(m_rd_ack),
    .ram_addr(fp_ram_addr), .ram_wr_data(fp_ram_wr_data), .ram_wr_en(fp_ram_wr_en),
    .ram_rd_en(fp_ram_rd_en), .ram_busy(ram_busy), .ram_rd_data(ram_rd_data),
    .ram_rd_ready(ram_rd_ready), .ram_rd_ack(fp_ram_rd_ack), .grant(fp_grant)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance to one time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int ch, input logic wr, input logic rd,
                               input logic [AW-1:0] addr, input logic [DW-1:0] data);
    m_wr_en[ch]             = wr;
    m_rd_en[ch]             = rd;
    m_addr[ch*AW +: AW]     = addr;
    m_wr_data[ch*DW +: DW]  = data;
  endtask

  // Directed sequence covering reset, writes, read routing, fairness,
  // stalls, withdrawal, blocking during reads and reset mid-read.
  initial begin
    rst = 1'b0; m_addr = '0; m_wr_data = '0; m_wr_en = '0; m_rd_en = '0;
    m_rd_ack = '0; ram_busy = 1'b0; ram_rd_data = '0; ram_rd_ready = 1'b0;
    #2;
    checkOutput("reset_busy", 64'(m_busy), 64'h7);
    checkOutput("reset_wr_en", 64'(ram_wr_en), 64'h0);
    checkOutput("reset_rd_en", 64'(ram_rd_en), 64'h0);
    checkOutput("reset_rd_ack", 64'(ram_rd_ack), 64'h0);
    checkOutput("reset_addr", 64'(ram_addr), 64'h0);
    checkOutput("reset_wdata", 64'(ram_wr_data), 64'h0);
    checkOutput("reset_rd_ready", 64'(m_rd_ready), 64'h0);
    checkOutput("reset_rd_data", 64'(m_rd_data), 64'h0);
    checkOutput("reset_grant", 64'(grant), 64'h0);
    tick(); rst = 1'b1;
    tick();

    // Single write on channel 0.
    applyStimulus(0, 1'b1, 1'b0, 24'h000010, 16'hBEEF);
    #1;
    checkOutput("wr_idle_no_en", 64'(ram_wr_en), 64'h0);
    checkOutput("wr_idle_busy", 64'(m_busy), 64'h7);
    tick();
    checkOutput("wr_grant", 64'(grant), 64'h0);
    checkOutput("wr_en", 64'(ram_wr_en), 64'h1);
    checkOutput("wr_rd_en", 64'(ram_rd_en), 64'h0);
    checkOutput("wr_addr", 64'(ram_addr), 64'h000010);
    checkOutput("wr_data", 64'(ram_wr_data), 64'hBEEF);
    checkOutput("wr_busy", 64'(m_busy), 64'h6);
    tick();
    applyStimulus(0, 1'b0, 1'b0, 24'h0, 16'h0);
    #1;
    checkOutput("wr_en_one_cycle", 64'(ram_wr_en), 64'h0);
    checkOutput("wr_back_idle_busy", 64'(m_busy), 64'h7);

    // Read routing to channel 1.
    tick();
    applyStimulus(1, 1'b0, 1'b1, 24'h000020, 16'h0);
    tick();
    checkOutput("rd_grant", 64'(grant), 64'h1);
    checkOutput("rd_en", 64'(ram_rd_en), 64'h1);
    checkOutput("rd_addr", 64'(ram_addr), 64'h000020);
    checkOutput("rd_busy", 64'(m_busy), 64'h5);
    tick();
    applyStimulus(1, 1'b0, 1'b0, 24'h0, 16'h0);
    #1;
    checkOutput("rd_wait_en", 64'(ram_rd_en), 64'h0);
    checkOutput("rd_wait_busy", 64'(m_busy), 64'h7);
    repeat (4) begin
      tick();
      checkOutput("rd_wait_no_ready", 64'(m_rd_ready), 64'h0);
    end
    ram_rd_ready = 1'b1; ram_rd_data = 16'h1234;
    #1;
    checkOutput("rd_ready_route", 64'(m_rd_ready), 64'h2);
    checkOutput("rd_data_route", 64'(m_rd_data), 64'h0000_1234_0000);
    checkOutput("rd_no_ack_yet", 64'(ram_rd_ack), 64'h0);
    tick();
    m_rd_ack = 3'b001;
    #1;
    checkOutput("rd_nonowner_ack", 64'(ram_rd_ack), 64'h0);
    tick();
    m_rd_ack = 3'b000;
    #1;
    checkOutput("rd_held_ack", 64'(ram_rd_ack), 64'h0);
    tick();
    m_rd_ack = 3'b010;
    #1;
    checkOutput("rd_ack_pulse", 64'(ram_rd_ack), 64'h1);
    tick();
    checkOutput("rd_after_ack_ready", 64'(m_rd_ready), 64'h0);
    checkOutput("rd_after_ack_ack", 64'(ram_rd_ack), 64'h0);
    ram_rd_ready = 1'b0; m_rd_ack = '0;
    // A stray ram_rd_ready in IDLE must not be forwarded or acknowledged.
    tick();
    ram_rd_ready = 1'b1; m_rd_ack = 3'b010;
    #1;
    checkOutput("spurious_ready", 64'(m_rd_ready), 64'h0);
    checkOutput("spurious_ack", 64'(ram_rd_ack), 64'h0);
    ram_rd_ready = 1'b0; m_rd_ack = '0;

    // Fairness with all three channels writing continuously, from reset.
    tick();
    rst = 1'b0;
    #2 rst = 1'b1;
    for (int c = 0; c < NCH; c++)
      applyStimulus(c, 1'b1, 1'b0, 24'(24'h100 + c), 16'(16'hA000 + c));
    for (int n = 0; n < 6; n++) begin
      tick();
      checkOutput("rr_grant", 64'(grant), 64'(exp_order[n]));
      checkOutput("rr_addr", 64'(ram_addr), 64'(24'h100 + exp_order[n]));
      checkOutput("rr_wr_en", 64'(ram_wr_en), 64'h1);
      checkOutput("fp_grant", 64'(fp_grant), 64'h0);
      checkOutput("fp_wr_en", 64'(fp_ram_wr_en), 64'h1);
      tick();
      checkOutput("rr_gap", 64'(ram_wr_en), 64'h0);
      checkOutput("fp_gap", 64'(fp_ram_wr_en), 64'h0);
    end
    m_wr_en = '0;

    // Busy stall for four cycles, then channel 0 withdraws.
    tick();
    ram_busy = 1'b1;
    applyStimulus(0, 1'b1, 1'b0, 24'h000200, 16'h1111);
    applyStimulus(1, 1'b1, 1'b0, 24'h000201, 16'h2222);
    repeat (4) begin
      tick();
      checkOutput("stall_grant", 64'(grant), 64'h0);
      checkOutput("stall_busy", 64'(m_busy), 64'h7);
      checkOutput("stall_wr_en", 64'(ram_wr_en), 64'h1);
    end
    applyStimulus(0, 1'b0, 1'b0, 24'h0, 16'h0);
    ram_busy = 1'b0;
    #1;
    checkOutput("withdraw_wr_en", 64'(ram_wr_en), 64'h0);
    tick();
    checkOutput("withdraw_idle_busy", 64'(m_busy), 64'h7);
    checkOutput("withdraw_idle_en", 64'(ram_wr_en), 64'h0);
    tick();
    checkOutput("after_withdraw_grant", 64'(grant), 64'h1);
    checkOutput("after_withdraw_addr", 64'(ram_addr), 64'h000201);
    checkOutput("after_withdraw_busy", 64'(m_busy), 64'h5);
    tick();
    applyStimulus(1, 1'b0, 1'b0, 24'h0, 16'h0);

    // Channel 0 read blocks a channel 1 write until the acknowledge.
    tick();
    applyStimulus(0, 1'b0, 1'b1, 24'h000300, 16'h0);
    tick();
    checkOutput("blk_grant", 64'(grant), 64'h0);
    checkOutput("blk_rd_en", 64'(ram_rd_en), 64'h1);
    tick();
    applyStimulus(0, 1'b0, 1'b0, 24'h0, 16'h0);
    applyStimulus(1, 1'b1, 1'b0, 24'h000301, 16'h5555);
    #1;
    checkOutput("blk_wait_busy", 64'(m_busy), 64'h7);
    checkOutput("blk_wait_wr_en", 64'(ram_wr_en), 64'h0);
    repeat (2) begin
      tick();
      checkOutput("blk_ch1_busy", 64'(m_busy[1]), 64'h1);
    end
    ram_rd_ready = 1'b1; ram_rd_data = 16'hCAFE; m_rd_ack = 3'b001;
    #1;
    checkOutput("blk_rd_data", 64'(m_rd_data), 64'h0000_0000_CAFE);
    checkOutput("blk_rd_ack", 64'(ram_rd_ack), 64'h1);
    tick();
    ram_rd_ready = 1'b0; m_rd_ack = '0;
    #1;
    checkOutput("blk_idle_busy", 64'(m_busy), 64'h7);
    tick();
    checkOutput("blk_wr_grant", 64'(grant), 64'h1);
    checkOutput("blk_wr_en", 64'(ram_wr_en), 64'h1);
    checkOutput("blk_wr_data", 64'(ram_wr_data), 64'h5555);
    checkOutput("blk_wr_busy", 64'(m_busy), 64'h5);
    tick();
    applyStimulus(1, 1'b0, 1'b0, 24'h0, 16'h0);

    // Write and read both set on channel 2: treated as a write only.
    tick();
    applyStimulus(2, 1'b1, 1'b1, 24'h000400, 16'h7E57);
    tick();
    checkOutput("both_grant", 64'(grant), 64'h2);
    checkOutput("both_wr_en", 64'(ram_wr_en), 64'h1);
    checkOutput("both_rd_en", 64'(ram_rd_en), 64'h0);
    tick();
    applyStimulus(2, 1'b0, 1'b0, 24'h0, 16'h0);
    ram_rd_ready = 1'b1; m_rd_ack = 3'b100;
    #1;
    checkOutput("both_no_wait_ack", 64'(ram_rd_ack), 64'h0);
    checkOutput("both_no_wait_ready", 64'(m_rd_ready), 64'h0);
    ram_rd_ready = 1'b0; m_rd_ack = '0;

    // Reset asserted while a read is outstanding.
    tick();
    applyStimulus(1, 1'b0, 1'b1, 24'h000020, 16'h0);
    tick();
    checkOutput("rst_rd_grant", 64'(grant), 64'h1);
    tick();
    applyStimulus(1, 1'b0, 1'b0, 24'h0, 16'h0);
    ram_rd_ready = 1'b1; ram_rd_data = 16'h7777;
    #1;
    checkOutput("rst_pre_ready", 64'(m_rd_ready), 64'h2);
    #1 rst = 1'b0;
    #1;
    checkOutput("rst_async_ready", 64'(m_rd_ready), 64'h0);
    checkOutput("rst_async_data", 64'(m_rd_data), 64'h0);
    checkOutput("rst_async_busy", 64'(m_busy), 64'h7);
    checkOutput("rst_async_grant", 64'(grant), 64'h0);
    ram_rd_ready = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    applyStimulus(1, 1'b0, 1'b1, 24'h000040, 16'h0);
    tick();
    checkOutput("fresh_grant", 64'(grant), 64'h1);
    checkOutput("fresh_rd_en", 64'(ram_rd_en), 64'h1);
    checkOutput("fresh_addr", 64'(ram_addr), 64'h000040);
    tick();
    applyStimulus(1, 1'b0, 1'b0, 24'h0, 16'h0);
    ram_rd_ready = 1'b1; ram_rd_data = 16'h4242; m_rd_ack = 3'b010;
    #1;
    checkOutput("fresh_rd_data", 64'(m_rd_data), 64'h0000_4242_0000);
    checkOutput("fresh_rd_ack", 64'(ram_rd_ack), 64'h1);
    tick();
    ram_rd_ready = 1'b0; m_rd_ack = '0;
    #1;
    checkOutput("fresh_done_busy", 64'(m_busy), 64'h7);
    checkOutput("fresh_done_ack", 64'(ram_rd_ack), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
